// File: rtl/traffic_phase_sequencer_if.sv
// Phase-code interface between the sequencer and the light decoder.
// The sequencer drives the phase side; sensors and tick enter here.
interface traffic_phase_sequencer_if #(
  parameter int CNT_W = 6
);
  logic             tick;
  logic             left_req_ew;
  logic             left_req_ns;
  logic [2:0]       phase;
  logic             phase_change;
  logic [CNT_W-1:0] time_left;

  modport master (
    input  tick,
    input  left_req_ew,
    input  left_req_ns,
    output phase,
    output phase_change,
    output time_left
  );

  modport slave (
    output tick,
    output left_req_ew,
    output left_req_ns,
    input  phase,
    input  phase_change,
    input  time_left
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Eight-phase intersection sequencer timed by a 1 Hz tick.
// Left-arrow phases run only when a turn request is pending.
module traffic_phase_sequencer #(
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_LEFT   = 8,
  parameter int CNT_W    = 6
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  traffic_phase_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    RED_A  = 3'd2,
    EW_LFT = 3'd3,
    EW_GRN = 3'd4,
    EW_YEL = 3'd5,
    RED_B  = 3'd6,
    NS_LFT = 3'd7
  } phase_e;

  phase_e           phase_q, phase_d, succ;
  logic [CNT_W-1:0] time_q, time_d;
  logic             chg_q, chg_d;
  logic             ew_q, ew_d;
  logic             ns_q, ns_d;
  logic             ew_pend, ns_pend;

  function automatic logic [CNT_W-1:0] reload(phase_e p);
    logic [CNT_W-1:0] v;
    v = CNT_W'(T_ALLRED - 1);
    unique case (p)
      NS_GRN, EW_GRN: v = CNT_W'(T_GREEN - 1);
      NS_YEL, EW_YEL: v = CNT_W'(T_YELLOW - 1);
      RED_A, RED_B:   v = CNT_W'(T_ALLRED - 1);
      EW_LFT, NS_LFT: v = CNT_W'(T_LEFT - 1);
    endcase
    return v;
  endfunction

  assign ew_pend = ew_q | bus.left_req_ew;
  assign ns_pend = ns_q | bus.left_req_ns;

  always_comb begin
    succ = NS_GRN;
    unique case (phase_q)
      NS_GRN: succ = NS_YEL;
      NS_YEL: succ = RED_A;
      RED_A:  succ = ew_pend ? EW_LFT : EW_GRN;
      EW_LFT: succ = EW_GRN;
      EW_GRN: succ = EW_YEL;
      EW_YEL: succ = RED_B;
      RED_B:  succ = ns_pend ? NS_LFT : NS_GRN;
      NS_LFT: succ = NS_GRN;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    time_d  = time_q;
    chg_d   = 1'b0;
    if (bus.tick) begin
      if (time_q != '0) begin
        time_d = time_q - CNT_W'(1);
      end else begin
        phase_d = succ;
        time_d  = reload(succ);
        chg_d   = 1'b1;
      end
    end
    // the served phase discards its own request, even a fresh one
    ew_d = (phase_q == EW_LFT) ? 1'b0 : ew_pend;
    ns_d = (phase_q == NS_LFT) ? 1'b0 : ns_pend;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      phase_q <= RED_B;
      time_q  <= CNT_W'(T_ALLRED - 1);
      chg_q   <= 1'b0;
      ew_q    <= 1'b0;
      ns_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      time_q  <= time_d;
      chg_q   <= chg_d;
      ew_q    <= ew_d;
      ns_q    <= ns_d;
    end
  end

  assign bus.phase        = phase_q;
  assign bus.time_left    = time_q;
  assign bus.phase_change = chg_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboarded random and directed bench for the phase sequencer.
// Model tracks ticks remaining per phase and pending turn requests.
module tb_traffic_phase_sequencer;

  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_phase_sequencer_if #(.CNT_W(CNT_W)) bus();

  traffic_phase_sequencer #(
    .T_GREEN (20),
    .T_YELLOW(3),
    .T_ALLRED(2),
    .T_LEFT  (8),
    .CNT_W   (CNT_W)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int cyc;
    int ph;
    int tl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dur[8] = '{20, 3, 2, 8, 20, 3, 2, 8};
  int   m_ph, m_rem, tk;
  bit   m_ew, m_ns;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.phase_change) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: phase %0d at cycle %0d",
                 bus.phase, cyc);
      end else begin
        e = q.pop_front();
        chk("chg_cycle", cyc, e.cyc);
        chk("chg_phase", int'(bus.phase), e.ph);
        chk("chg_time", int'(bus.time_left), e.tl);
      end
    end
  end

  task automatic model_reset();
    m_ph = 6;
    m_rem = 2;
    m_ew = 1'b0;
    m_ns = 1'b0;
    tk = 0;
    q.delete();
  endtask

  // Reference: whole-tick countdown, then next phase in ring order,
  // skipping a left phase unless its request is pending.
  task automatic model(bit t, bit e, bit n);
    int   old, nx;
    bit   pe, pn;
    exp_t x;
    old = m_ph;
    pe = m_ew | e;
    pn = m_ns | n;
    if (t) begin
      if (m_rem > 1) begin
        m_rem--;
      end else begin
        nx = (m_ph + 1) % 8;
        if (nx == 3 && !pe) nx = 4;
        if (nx == 7 && !pn) nx = 0;
        m_ph = nx;
        m_rem = dur[nx];
        x.cyc = cyc + 1;
        x.ph = nx;
        x.tl = dur[nx] - 1;
        q.push_back(x);
      end
    end
    m_ew = (old == 3) ? 1'b0 : pe;
    m_ns = (old == 7) ? 1'b0 : pn;
  endtask

  task automatic step(bit t, bit e, bit n);
    bus.tick = t;
    bus.left_req_ew = e;
    bus.left_req_ns = n;
    model(t, e, n);
    @(posedge clk);
    #1;
  endtask

  task automatic tstep(bit e, bit n);
    bit t;
    t = (tk % 4 == 3);
    tk++;
    step(t, e, n);
  endtask

  task automatic run_until(int ph, int rem, string nm);
    int b;
    b = 0;
    while (!(m_ph == ph && m_rem == rem) && b < 3000) begin
      tstep(1'b0, 1'b0);
      b++;
    end
    if (b >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting phase %0d rem %0d", nm, ph, rem);
    end
  endtask

  task automatic exit_from(int ph, string nm);
    int b;
    b = 0;
    while (m_ph == ph && b < 500) begin
      tstep(1'b0, 1'b0);
      b++;
    end
    if (b >= 500) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout leaving phase %0d", nm, ph);
    end
  endtask

  task automatic chk_state(string nm);
    chk({nm, "_phase"}, int'(bus.phase), m_ph);
    chk({nm, "_time"}, int'(bus.time_left), m_rem - 1);
  endtask

  initial begin
    int seen;
    int b;
    bus.tick = 1'b0;
    bus.left_req_ew = 1'b0;
    bus.left_req_ns = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase", int'(bus.phase), 6);
    chk("rst_time", int'(bus.time_left), 1);
    chk("rst_chg", int'(bus.phase_change), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_chg", int'(bus.phase_change), 0);
    chk("rel_phase", int'(bus.phase), 6);

    repeat (8) tstep(1'b0, 1'b0);
    chk("first_phase", int'(bus.phase), 0);
    chk("first_time", int'(bus.time_left), 19);
    chk("first_chg", int'(bus.phase_change), 1);
    tstep(1'b0, 1'b0);
    chk("chg_one_cycle", int'(bus.phase_change), 0);

    run_until(4, 20, "idle_to_ewgrn");
    chk_state("idle_ewgrn");
    run_until(6, 1, "idle_to_red");
    exit_from(6, "idle_exit6");
    chk("idle_skip7", int'(bus.phase), 0);

    step(1'b0, 1'b1, 1'b0);
    run_until(3, 8, "ew_left");
    chk_state("ew_left");
    run_until(4, 20, "ew_after_left");
    run_until(2, 1, "ew_second_pass");
    exit_from(2, "ew_exit2");
    chk("ew_skip3_again", int'(bus.phase), 4);

    run_until(6, 1, "same_edge");
    step(1'b1, 1'b0, 1'b1);
    chk("same_edge_ns", int'(bus.phase), 7);

    run_until(0, 20, "hold_start");
    step(1'b0, 1'b1, 1'b0);
    run_until(3, 8, "hold_left");
    b = 0;
    while (m_ph == 3 && b < 200) begin
      tstep(1'b1, 1'b0);
      b++;
    end
    run_until(2, 1, "hold_next2");
    exit_from(2, "hold_exit2");
    chk("hold_discard", int'(bus.phase), 4);

    run_until(4, 6, "gate");
    chk_state("gate_pre");
    seen = 0;
    repeat (1000) begin
      step(1'b0, 1'b0, 1'b0);
      seen += int'(bus.phase_change);
    end
    chk("gate_phase", int'(bus.phase), 4);
    chk("gate_time", int'(bus.time_left), 5);
    chk("gate_chg", seen, 0);

    run_until(0, 20, "async_start");
    step(1'b0, 1'b1, 1'b1);
    run_until(3, 4, "async_mid3");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_phase", int'(bus.phase), 6);
    chk("async_time", int'(bus.time_left), 1);
    chk("async_chg", int'(bus.phase_change), 0);
    model_reset();
    bus.tick = 1'b0;
    bus.left_req_ew = 1'b0;
    bus.left_req_ns = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_until(6, 1, "async_tick");
    exit_from(6, "async_exit6");
    chk("async_to0", int'(bus.phase), 0);

    repeat (4000) begin
      step($urandom_range(0, 2) == 0,
           $urandom_range(0, 30) == 0,
           $urandom_range(0, 30) == 0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_state("final");
    chk("queue_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Sequential controller that generates the 3-bit intersection phase code consumed by the light-decoding datapath, i.e. the producing end of the phase-code interface. It steps through the eight-phase cycle (NS green, NS yellow, all-red, EW left, EW green, EW yellow, all-red, NS left), timing each phase in whole seconds from the 1 Hz enable pulse produced by the counter chain. Left-arrow phases are served only when a left-turn request is pending; otherwise they are skipped.

## Interface
- T_GREEN, 20, through-green duration in ticks (seconds), phases 0 and 4
- T_YELLOW, 3, yellow duration in ticks, phases 1 and 5
- T_ALLRED, 2, all-red clearance duration in ticks, phases 2 and 6
- T_LEFT, 8, left-arrow duration in ticks, phases 3 and 7
- CNT_W, 6, phase timer width; every T_* must be in the range 1 .. 2^CNT_W
- CLOCK_50  in  1  system clock; one clock domain
- resetn  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle enable pulse, one per second, synchronous to CLOCK_50
- left_req_ew  in  1  EW left-turn car sensor, level or pulse
- left_req_ns  in  1  NS left-turn car sensor, level or pulse
- phase  out  3  phase code: 0 NS green, 1 NS yellow, 2 all-red, 3 EW left, 4 EW green, 5 EW yellow, 6 all-red, 7 NS left
- phase_change  out  1  one-cycle pulse, high in the first cycle of every new phase
- time_left  out  CNT_W  remaining ticks in current phase minus one

## Operation
- Reset: phase=6, time_left=T_ALLRED-1, phase_change=0, both request latches cleared.
- Phase timer: on phase entry it loads T_x-1 for the new phase. On a cycle with tick=1:
  - if time_left≠0, it decrements;
  - if time_left=0, the phase advances.
- Cycles with tick=0 change no timer state. Every phase therefore lasts exactly T_x ticks.
- Successor rules:
  - 0→1, 1→2, 3→4, 4→5, 5→6, 7→0 unconditionally.
  - 2→3 if ew_pend, else 2→4.
  - 6→7 if ns_pend, else 6→0.
- Pending request: ew_pend = ew_latch | left_req_ew, evaluated in the cycle the phase-2 exit decision is made. ns_pend is the same for NS at the phase-6 exit.
- Request latches:
  - ew_latch sets on any cycle with left_req_ew=1 and phase≠3.
  - ew_latch clears on every cycle with phase=3. A request during its own left phase is therefore discarded.
  - ns_latch follows the same rules against phase 7.
  - When clear and set conditions coincide, clear wins (this only occurs in the served phase).
- Reachability: phase codes 3 and 7 are never emitted without a pending request. Green phases (0, 4) are never entered from any phase other than those listed above.
- No illegal states exist: all 3-bit codes are valid. The timer must never underflow.

## Timing
- phase, time_left and phase_change are registered outputs; no combinational path from inputs to outputs.
- Transition edge: the CLOCK_50 rising edge on which tick=1 and time_left=0. The new phase and its reload value are visible on the following cycle.
- phase_change is 1 for exactly that one cycle, then returns to 0. It is 0 out of reset, including the first cycle after resetn deasserts.
- Latency from the final tick to the new phase is 1 clock cycle.
- A sensor pulse of one cycle is sufficient, provided it is not in the served phase.
- A request arriving on the same edge as the exit decision is honoured.
- Reset mid-phase: outputs go to reset values immediately (asynchronous) and pending requests are lost. After release, the sequence restarts at phase 6.
- Back-to-back ticks on consecutive cycles are legal; each one counts.

## Test plan
- Reset and idle cycle: no requests, 1 tick per 4 clocks, defaults.
  - After reset: phase=6, time_left=1.
  - 2 ticks later: phase 0, with a single-cycle phase_change.
  - Then 20 ticks in 0, 3 in 1, 2 in 2, then 4 (3 skipped), 20 in 4, 3 in 5, 2 in 6, then 0 (7 skipped).
- EW left served: pulse left_req_ew for 1 cycle during phase 0.
  - Phase 2 exits to 3, which lasts 8 ticks, then 4.
  - The next cycle skips 3 again.
- Same-edge request: assert left_req_ns only on the cycle of the final tick of phase 6.
  - Next phase is 7, not 0.
- Request during served phase: hold left_req_ew high throughout phase 3, then low.
  - The next pass through phase 2 goes to 4 (latch cleared).
- Tick gating: hold tick=0 for 1000 cycles in phase 4 with time_left=5.
  - phase and time_left are unchanged, and phase_change stays 0.
- Async reset mid-phase: assert resetn=0 between clock edges during phase 3 with ns_latch set.
  - Outputs immediately go to phase=6, time_left=1, phase_change=0.
  - After release with no requests, 6 exits to 0.
